// File: rtl/video_out_v3.sv
// video_out_v3: 640x480@60 VGA timing generator for the DVI transmitter.
// Fetches one 384-bit row (128 pixels x 3 bits) per window line from the
// output BRAM and shows it in a 128x128 window. Frame ownership is traded
// with the processing module through vld_i / rdy_o.
module video_out_v3 #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int WIN_X0   = 416,
    parameter int WIN_Y0   = 196,
    parameter int WIN_W    = 128,
    parameter int WIN_H    = 128
) (
    input  logic         pixel_clk_i,
    input  logic         rst_i,
    input  logic         video_ACK_i,
    output logic [6:0]   addrb_bram_o,
    output logic         enb_bram_o,
    input  logic [383:0] doutb_bram_i,
    input  logic         vld_i,
    output logic         rdy_o,
    output logic         frame_done_o,
    output logic         hsync_o,
    output logic         vsync_o,
    output logic         de_o,
    output logic [7:0]   red_o,
    output logic [7:0]   green_o,
    output logic [7:0]   blue_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_V  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_V  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] WX_FIRST = 11'(WIN_X0);
    localparam logic [10:0] WX_LAST  = 11'(WIN_X0 + WIN_W - 1);
    localparam logic [10:0] WY_FIRST = 11'(WIN_Y0);
    localparam logic [10:0] WY_LAST  = 11'(WIN_Y0 + WIN_H - 1);
    localparam logic [10:0] WY_DONE  = 11'(WIN_Y0 + WIN_H);
    // BRAM data for the row requested at h=0 is valid two cycles later
    localparam logic [10:0] H_LOAD   = 11'd2;
    localparam logic [23:0] GREY     = 24'h808080;

    // Each 3-bit pixel {R,G,B} expands to full-scale 8-bit channels
    function automatic logic [23:0] expand_pix(input logic [2:0] pix);
        return {{8{pix[2]}}, {8{pix[1]}}, {8{pix[0]}}};
    endfunction

    logic [10:0]  h_cnt_r;
    logic [10:0]  v_cnt_r;
    logic         frame_vld_r;
    logic [383:0] row_r;

    logic         hsync_s;
    logic         vsync_s;
    logic         de_s;
    logic         win_line_s;
    logic         win_col_s;
    logic         frame_start_s;
    logic         fetch_s;
    logic         load_s;
    logic         shift_s;
    logic         rdy_s;
    logic         done_s;
    logic [23:0]  rgb_s;

    // Decode the current counter position into next output values
    always_comb begin
        hsync_s       = ~((h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST));
        vsync_s       = ~((v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST));
        de_s          = (h_cnt_r < H_ACT_V) && (v_cnt_r < V_ACT_V);
        win_line_s    = (v_cnt_r >= WY_FIRST) && (v_cnt_r <= WY_LAST);
        win_col_s     = (h_cnt_r >= WX_FIRST) && (h_cnt_r <= WX_LAST);
        frame_start_s = (h_cnt_r == 11'd0) && (v_cnt_r == 11'd0);
        fetch_s       = win_line_s && frame_vld_r && (h_cnt_r == 11'd0);
        load_s        = win_line_s && frame_vld_r && (h_cnt_r == H_LOAD);
        shift_s       = win_line_s && frame_vld_r && win_col_s;
        rdy_s         = ~(win_line_s && frame_vld_r);
        done_s        = frame_vld_r && (v_cnt_r == WY_DONE) && (h_cnt_r == 11'd0);
        rgb_s         = 24'h000000;
        if (de_s && win_line_s && win_col_s) begin
            if (frame_vld_r) begin
                rgb_s = expand_pix(row_r[383:381]);
            end else begin
                rgb_s = GREY;
            end
        end else begin
            rgb_s = 24'h000000;
        end
    end

    // Counters, frame latch, row shifter and registered outputs
    always_ff @(posedge pixel_clk_i) begin
        if (rst_i || !video_ACK_i) begin
            h_cnt_r      <= 11'd0;
            v_cnt_r      <= 11'd0;
            frame_vld_r  <= 1'b0;
            row_r        <= 384'd0;
            hsync_o      <= 1'b1;
            vsync_o      <= 1'b1;
            de_o         <= 1'b0;
            red_o        <= 8'h00;
            green_o      <= 8'h00;
            blue_o       <= 8'h00;
            addrb_bram_o <= 7'd0;
            enb_bram_o   <= 1'b0;
            rdy_o        <= 1'b1;
            frame_done_o <= 1'b0;
        end else begin
            if (h_cnt_r == H_LAST) begin
                h_cnt_r <= 11'd0;
                if (v_cnt_r == V_LAST) begin
                    v_cnt_r <= 11'd0;
                end else begin
                    v_cnt_r <= v_cnt_r + 11'd1;
                end
            end else begin
                h_cnt_r <= h_cnt_r + 11'd1;
            end

            // Ownership decision is taken once per frame and held
            if (frame_start_s) begin
                frame_vld_r <= vld_i;
            end

            if (load_s) begin
                row_r <= doutb_bram_i;
            end else if (shift_s) begin
                row_r <= {row_r[380:0], 3'b000};
            end

            if (fetch_s) begin
                addrb_bram_o <= 7'(v_cnt_r - WY_FIRST);
            end
            enb_bram_o   <= fetch_s;

            hsync_o      <= hsync_s;
            vsync_o      <= vsync_s;
            de_o         <= de_s;
            {red_o, green_o, blue_o} <= rgb_s;
            rdy_o        <= rdy_s;
            frame_done_o <= done_s;
        end
    end

endmodule
